// File: rtl/pkt_rr_arbiter.sv
// Two-input packet-granular round-robin AXI-stream arbiter with one registered output stage
// and per-requester packet counters. Reset assertion is asynchronous; release is synchronised.
module pkt_rr_arbiter #(
  parameter int AXIS_TDATA_WIDTH = 512,
  parameter int AXIS_TID_WIDTH   = 8,
  parameter bit TAG_ID           = 1'b1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axis_0_tvalid,
  output logic                            s_axis_0_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_0_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0]   s_axis_0_tkeep,
  input  logic [AXIS_TID_WIDTH-1:0]       s_axis_0_tid,
  input  logic                            s_axis_0_tlast,
  input  logic                            s_axis_1_tvalid,
  output logic                            s_axis_1_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_1_tdata,
  input  logic [AXIS_TDATA_WIDTH/8-1:0]   s_axis_1_tkeep,
  input  logic [AXIS_TID_WIDTH-1:0]       s_axis_1_tid,
  input  logic                            s_axis_1_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
  output logic [AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [AXIS_TID_WIDTH-1:0]       m_axis_tid,
  output logic                            m_axis_tlast,
  output logic [1:0]                      grant,
  output logic [31:0]                     pkt_cnt_0,
  output logic [31:0]                     pkt_cnt_1
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;

  logic [1:0] rst_sync_q;
  logic       rst_n;
  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       out_valid_q;
  logic [AXIS_TDATA_WIDTH-1:0]   data_q, sel_data;
  logic [AXIS_TDATA_WIDTH/8-1:0] keep_q, sel_keep;
  logic [AXIS_TID_WIDTH-1:0]     id_q, sel_tid, sel_id;
  logic       last_q, sel_last;
  logic [31:0] pkt_cnt_0_q, pkt_cnt_1_q;
  logic       ready_0, ready_1, acc_0, acc_1, acc;

  // Reset asserts immediately but releases two clean edges after areset rises.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign ready_0 = (state_q == G0) && (!out_valid_q || m_axis_tready);
  assign ready_1 = (state_q == G1) && (!out_valid_q || m_axis_tready);
  assign acc_0   = s_axis_0_tvalid && ready_0;
  assign acc_1   = s_axis_1_tvalid && ready_1;
  assign acc     = acc_0 || acc_1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (s_axis_0_tvalid && (!s_axis_1_tvalid || !rr_q)) state_d = G0;
        else if (s_axis_1_tvalid)                            state_d = G1;
      end
      G0: begin
        if (acc_0 && s_axis_0_tlast) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end
      end
      G1: begin
        if (acc_1 && s_axis_1_tlast) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_data = s_axis_0_tdata;
    sel_keep = s_axis_0_tkeep;
    sel_tid  = s_axis_0_tid;
    sel_last = s_axis_0_tlast;
    if (state_q == G1) begin
      sel_data = s_axis_1_tdata;
      sel_keep = s_axis_1_tkeep;
      sel_tid  = s_axis_1_tid;
      sel_last = s_axis_1_tlast;
    end
  end

  assign sel_id = TAG_ID ? AXIS_TID_WIDTH'(state_q == G1) : sel_tid;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      pkt_cnt_0_q <= 32'd0;
      pkt_cnt_1_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      // Fields only change on a new accept, so a stalled beat stays stable.
      if (acc) begin
        out_valid_q <= 1'b1;
        data_q      <= sel_data;
        keep_q      <= sel_keep;
        id_q        <= sel_id;
        last_q      <= sel_last;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      if (acc_0 && s_axis_0_tlast) pkt_cnt_0_q <= pkt_cnt_0_q + 32'd1;
      if (acc_1 && s_axis_1_tlast) pkt_cnt_1_q <= pkt_cnt_1_q + 32'd1;
    end
  end

  always_comb begin
    grant = 2'b00;
    case (state_q)
      G0:      grant = 2'b01;
      G1:      grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign s_axis_0_tready = ready_0;
  assign s_axis_1_tready = ready_1;
  assign m_axis_tvalid   = out_valid_q;
  assign m_axis_tdata    = data_q;
  assign m_axis_tkeep    = keep_q;
  assign m_axis_tid      = id_q;
  assign m_axis_tlast    = last_q;
  assign pkt_cnt_0       = pkt_cnt_0_q;
  assign pkt_cnt_1       = pkt_cnt_1_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Randomised bench for pkt_rr_arbiter: input-side handshakes feed a scoreboard queue that an
// independent output monitor drains; arbitration order is predicted from the round-robin rules.
module tb_pkt_rr_arbiter;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int IW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic          aclk;
  logic          areset;
  logic [1:0]    s_vld;
  logic [1:0]    s_rdy;
  beat_t         s_beat [2];
  logic          m_tvalid, m_rdy, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [IW-1:0] m_tid;
  logic [1:0]    grant;
  logic [31:0]   pkt_cnt_0, pkt_cnt_1;

  pkt_rr_arbiter #(.AXIS_TDATA_WIDTH(DW), .AXIS_TID_WIDTH(IW), .TAG_ID(1'b1)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_0_tvalid(s_vld[0]), .s_axis_0_tready(s_rdy[0]), .s_axis_0_tdata(s_beat[0].data),
    .s_axis_0_tkeep(s_beat[0].keep), .s_axis_0_tid(s_beat[0].id), .s_axis_0_tlast(s_beat[0].last),
    .s_axis_1_tvalid(s_vld[1]), .s_axis_1_tready(s_rdy[1]), .s_axis_1_tdata(s_beat[1].data),
    .s_axis_1_tkeep(s_beat[1].keep), .s_axis_1_tid(s_beat[1].id), .s_axis_1_tlast(s_beat[1].last),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_rdy), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tid(m_tid), .m_axis_tlast(m_tlast),
    .grant(grant), .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_assert = 0;
  int          n_fail   = 0;
  beat_t       src_q [2][$];
  beat_t       exp_q [$];
  logic [1:0]  hold;
  logic        ptr_m;
  logic [31:0] cnt_m [2];
  logic [1:0]  open_m;
  logic        done_m;
  logic [1:0]  prev_grant, prev_v;
  int          settle;
  int          mrdy_pct, gap_pct;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int n, input int len, input bit a5);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = a5 ? {8{8'hA5}} : {$urandom, $urandom};
      b.last = (i == len - 1);
      b.keep = b.last ? KW'($urandom_range(255, 1)) : {KW{1'b1}};
      b.id   = IW'($urandom);
      src_q[n].push_back(b);
    end
  endtask

  // One clock: check state left by the previous edge, drive, then record handshakes.
  task automatic cycle();
    logic [1:0] acc;
    logic       win;
    beat_t      e;
    @(negedge aclk);
    check("pkt_cnt_0", DW'(pkt_cnt_0), DW'(cnt_m[0]));
    check("pkt_cnt_1", DW'(pkt_cnt_1), DW'(cnt_m[1]));
    if (!areset) begin
      check("reset_grant", DW'(grant), 0);
      check("reset_m_tvalid", DW'(m_tvalid), 0);
    end else begin
      if (open_m[0])      check("grant_hold0", DW'(grant), 1);
      else if (open_m[1]) check("grant_hold1", DW'(grant), 2);
      else if (done_m)    check("idle_gap", DW'(grant), 0);
      if (prev_grant == 2'b00 && grant != 2'b00) begin
        if (prev_v == 2'b00) check("spurious_grant", DW'(grant), 0);
        else begin
          win = (prev_v == 2'b11) ? ptr_m : prev_v[1];
          check("rr_winner", DW'(grant), DW'(2'b01 << win));
        end
      end else if (prev_grant == 2'b00 && prev_v != 2'b00 && settle >= 4) begin
        check("prompt_grant", DW'(grant != 2'b00), 1);
      end
    end
    prev_grant = grant;
    done_m     = 1'b0;
    m_rdy = ($urandom_range(99) < mrdy_pct);
    for (int n = 0; n < 2; n++) begin
      if (!hold[n]) begin
        if (src_q[n].size() > 0 && $urandom_range(99) >= gap_pct) begin
          s_beat[n] = src_q[n].pop_front();
          s_vld[n]  = 1'b1;
        end else begin
          s_vld[n] = 1'b0;
        end
      end
    end
    #1;
    if (areset && settle < 1000) settle++;
    for (int n = 0; n < 2; n++)
      check($sformatf("tready_%0d", n), DW'(s_rdy[n]),
            DW'((grant == (2'b01 << n)) && (!m_tvalid || m_rdy)));
    prev_v = s_vld;
    acc    = s_vld & s_rdy;
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        check("no_interleave", DW'(open_m[1-n]), 0);
        e      = s_beat[n];
        e.id   = IW'(n);
        exp_q.push_back(e);
        open_m[n] = !s_beat[n].last;
        if (s_beat[n].last) begin
          cnt_m[n] = cnt_m[n] + 32'd1;
          ptr_m    = (n == 0);
          done_m   = 1'b1;
        end
        hold[n] = 1'b0;
      end else begin
        hold[n] = s_vld[n];
      end
    end
  endtask

  task automatic reset_assert();
    areset = 1'b0;
    #1;
    check("async_m_tvalid", DW'(m_tvalid), 0);
    check("async_grant", DW'(grant), 0);
    check("async_tready", DW'(s_rdy), 0);
    check("async_cnt0", DW'(pkt_cnt_0), 0);
    check("async_cnt1", DW'(pkt_cnt_1), 0);
    exp_q.delete();
    for (int n = 0; n < 2; n++) begin
      src_q[n].delete();
      cnt_m[n] = 32'd0;
    end
    s_vld = 2'b00; hold = 2'b00; open_m = 2'b00; done_m = 1'b0;
    ptr_m = 1'b0; settle = 0; prev_grant = 2'b00; prev_v = 2'b00;
  endtask

  task automatic drain(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      cycle();
      idle = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (s_vld == 2'b00) &&
             (exp_q.size() == 0) && !m_tvalid;
    end
    check({name, "_drained"}, DW'(idle), 1);
  endtask

  // Output monitor: stability under backpressure, then pop-and-compare on every handshake.
  initial begin
    bit    hold_out;
    beat_t cur, saved, e;
    hold_out = 1'b0;
    saved    = '0;
    forever begin
      @(negedge aclk);
      #2;
      cur = '{data: m_tdata, keep: m_tkeep, id: m_tid, last: m_tlast};
      if (!areset) begin
        hold_out = 1'b0;
      end else begin
        if (hold_out) begin
          check("stable_tvalid", DW'(m_tvalid), 1);
          check("stable_tdata", cur.data, saved.data);
          check("stable_side", DW'({cur.keep, cur.id, cur.last}), DW'({saved.keep, saved.id, saved.last}));
        end
        if (m_tvalid && m_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", DW'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            $display("beat: tid=%0d data=0x%0h keep=0x%0h last=%0b", cur.id, cur.data, cur.keep, cur.last);
            check("m_tdata", cur.data, e.data);
            check("m_tkeep", DW'(cur.keep), DW'(e.keep));
            check("m_tid", DW'(cur.id), DW'(e.id));
            check("m_tlast", DW'(cur.last), DW'(e.last));
          end
        end
        hold_out = m_tvalid && !m_rdy;
        saved    = cur;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b0; m_rdy = 1'b1; s_vld = 2'b00;
    s_beat[0] = '0; s_beat[1] = '0;
    mrdy_pct = 100; gap_pct = 0;
    reset_assert();
    repeat (2) cycle();
    // Contention with both requesters valid while still in reset.
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 2, 1'b0);
      add_pkt(1, 2, 1'b0);
    end
    repeat (2) cycle();
    areset = 1'b1;
    drain("contention");
    check("contention_cnt0", DW'(pkt_cnt_0), 3);
    check("contention_cnt1", DW'(pkt_cnt_1), 3);

    // Single requester, full-rate output.
    repeat (3) cycle();
    add_pkt(0, 4, 1'b0);
    drain("single");
    check("single_cnt0", DW'(pkt_cnt_0), 4);

    // Backpressure with a fixed data pattern.
    mrdy_pct = 40;
    add_pkt(0, 6, 1'b1);
    add_pkt(1, 4, 1'b1);
    drain("backpressure");

    // Random mix: input gaps mid-packet, random backpressure, random lengths.
    mrdy_pct = 70; gap_pct = 30;
    for (int k = 0; k < 30; k++) add_pkt($urandom_range(1), $urandom_range(5, 1), 1'b0);
    for (int k = 0; k < 5; k++) begin
      add_pkt(0, $urandom_range(4, 1), 1'b0);
      add_pkt(1, $urandom_range(4, 1), 1'b0);
    end
    drain("random");

    // Counter wrap from the all-ones value.
    mrdy_pct = 100; gap_pct = 0;
    force dut.pkt_cnt_0_q = 32'hFFFF_FFFF;
    cnt_m[0] = 32'hFFFF_FFFF;
    cycle();
    release dut.pkt_cnt_0_q;
    cycle();
    add_pkt(0, 2, 1'b0);
    drain("wrap");
    check("wrap_cnt0", DW'(pkt_cnt_0), 0);

    // Reset in the middle of an s1 packet while the pointer favours s1.
    add_pkt(0, 2, 1'b0);
    drain("pre_reset");
    add_pkt(1, 4, 1'b0);
    for (int i = 0; i < 60 && !open_m[1]; i++) cycle();
    check("midpkt_open", DW'(open_m[1]), 1);
    reset_assert();
    repeat (3) cycle();
    areset = 1'b1;
    repeat (5) cycle();
    add_pkt(0, 2, 1'b0);
    add_pkt(1, 3, 1'b0);
    drain("post_reset");
    check("post_reset_cnt0", DW'(pkt_cnt_0), 1);
    check("post_reset_cnt1", DW'(pkt_cnt_1), 1);
    check("final_queue_empty", DW'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 512: tdata width; tkeep width = AXIS_TDATA_WIDTH/8.
REQ-002 SHALL have parameter TAG_ID, default 1: 1 = output tid carries the granted requester index (zero-extended); 0 = input tid passes unchanged.
REQ-003 aclk  input  1  sole clock; all logic rising-edge.
REQ-004 areset  input  1  reset, asynchronous, active-low.
REQ-005 s_axis_0  AXI4SR.s  bundle  requester 0 stream (tvalid, tready, tdata, tkeep, tid, tlast).
REQ-006 s_axis_1  AXI4SR.s  bundle  requester 1 stream, same fields.
REQ-007 m_axis  AXI4SR.m  bundle  shared output toward the checksum/datapath chain.
REQ-008 grant  output  2  one-hot current grant; 00 when idle.
REQ-009 pkt_cnt_0  output  32  packets (tlast beats) forwarded from requester 0.
REQ-010 pkt_cnt_1  output  32  packets (tlast beats) forwarded from requester 1.

Function
REQ-011 SHALL arbitrate at packet granularity: once granted, a requester keeps the output until its tlast beat is accepted; no beat interleaving.
REQ-012 SHALL implement FSM states IDLE, G0, G1.
REQ-013 IDLE: if exactly one s tvalid high -> that requester's G state next cycle; if both high -> requester named by rr pointer; if none -> stay IDLE.
REQ-014 G0/G1: on accepted beat with tlast=1 -> IDLE; otherwise stay; one IDLE cycle always separates packets.
REQ-015 rr pointer SHALL reset to 0 and, on each completed packet, point to the requester that did NOT just finish.
REQ-016 Output SHALL be a single registered stage (out_valid, data, keep, id, last); latency input accept -> m_axis.tvalid = 1 cycle.
REQ-017 Granted s tready = (state is its G) AND (NOT out_valid OR m_axis.tready); non-granted tready = 0; IDLE both 0.
REQ-018 Register SHALL load on granted accept, clear out_valid on m_axis.tready without a new accept, and hold all fields while m_axis.tvalid=1 and m_axis.tready=0 (AXI-stream stability).
REQ-019 Throughput within a packet SHALL be one beat per cycle when m_axis.tready stays high.
REQ-020 m_axis.tid SHALL be granted index (TAG_ID=1) or input tid (TAG_ID=0); tkeep and tlast pass unmodified.
REQ-021 pkt_cnt_N SHALL increment by 1 when requester N's tlast beat is accepted on the input side; wraps 0xFFFFFFFF -> 0.
REQ-022 A requester dropping tvalid mid-packet SHALL NOT release the grant; FSM waits in its G state.
REQ-023 grant SHALL be decoded from FSM state: G0 -> 01, G1 -> 10, IDLE -> 00.

Reset
REQ-024 areset low SHALL asynchronously force: FSM IDLE, rr pointer 0, out_valid 0, m_axis.tvalid 0, both s tready 0, grant 00, pkt_cnt_0/1 = 0, data/keep/id/last registers 0.
REQ-025 Reset mid-packet SHALL discard the in-flight packet and partial output beat; after release arbitration restarts from IDLE with pointer 0.
REQ-026 Deassertion SHALL be synchronised inside the block so the first post-reset decision is on a clean edge.

Verification
REQ-027 Single requester: s0 sends 4-beat packet, m tready=1 -> grant 01 one cycle after s0 tvalid, 4 contiguous m beats, tlast on 4th, tid=0, pkt_cnt_0=1.
REQ-028 Contention: s0 and s1 both valid from reset with 2-beat packets, repeated -> output order s0,s1,s0,s1; one idle cycle between packets; pkt_cnt_0=pkt_cnt_1 after equal packet counts.
REQ-029 Backpressure: m tready low 3 cycles mid-packet with tdata=0xA5.. -> m_axis fields stable all 3 cycles, granted tready=0, no beat lost or duplicated.
REQ-030 Mid-packet gap: s1 drops tvalid 2 cycles inside a packet while s0 valid -> grant stays 10, no s0 beat emitted until s1 tlast.
REQ-031 Counter wrap: preload via 2^32-1 forced value on pkt_cnt_0 then one packet -> pkt_cnt_0=0.
REQ-032 Reset mid-packet: assert areset during beat 2 of 4 -> m tvalid=0 and grant=00 asynchronously; after release next s1 packet forwarded cleanly with pointer 0 behaviour.
